// File: rtl/tile_pkg.sv
// Shared constants and types for the tile game input path: opcodes, tile width
// and the default command queue depth.
package tile_pkg;

  localparam int TILE_W         = 4;
  localparam int OP_W           = 2;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic [OP_W-1:0] {
    OP_NONE    = 2'b00,
    OP_SELECT  = 2'b01,
    OP_CONFIRM = 2'b10,
    OP_RESTART = 2'b11
  } op_e;

  typedef struct packed {
    op_e               op;
    logic [TILE_W-1:0] tile;
  } cmd_t;

endpackage

// File: rtl/key_debounce.sv
// Debounces one already-synchronized active-low key and emits a one-cycle pulse
// one cycle after the debounced level falls (presses only, releases are silent).
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_sync,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic             key_state;
  logic             state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      key_state <= 1'b1;
      state_d   <= 1'b1;
      press     <= 1'b0;
    end else begin
      state_d <= key_state;
      press   <= state_d & ~key_state;
      // Any cycle agreeing with the accepted level restarts the stability count.
      if (key_sync == key_state) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        key_state <= key_sync;
        cnt       <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/tile_input_ctrl.sv
// Turns raw pushbuttons and the tile-index switches into SELECT/CONFIRM/RESTART
// commands held in a small first-word-fall-through queue for the game FSM.
module tile_input_ctrl
  import tile_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = FIFO_DEPTH_DEF
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic [2:0]        KEY,
  input  logic [9:0]        SW,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [OP_W-1:0]   cmd_op,
  output logic [TILE_W-1:0] cmd_tile,
  output logic [2:0]        fifo_count,
  output logic              overflow
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [2:0] key_s1, key_s2;
  logic [9:0] sw_s1, sw_s2;
  logic       sw_unused;
  logic [2:0] press;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      key_s1 <= '1;
      key_s2 <= '1;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      key_s1 <= KEY;
      key_s2 <= key_s1;
      sw_s1  <= SW;
      sw_s2  <= sw_s1;
    end
  end

  assign sw_unused = ^sw_s2[9:4];

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key1 (
    .clk(CLOCK_50), .rst_n(resetn), .key_sync(key_s2[0]), .press(press[0]));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key2 (
    .clk(CLOCK_50), .rst_n(resetn), .key_sync(key_s2[1]), .press(press[1]));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key3 (
    .clk(CLOCK_50), .rst_n(resetn), .key_sync(key_s2[2]), .press(press[2]));

  logic              pend_sel, pend_cfm, pend_rst;
  logic [TILE_W-1:0] sel_tile;
  logic              flush, pop, push, full, can_write;
  cmd_t              wr_cmd, head;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  cmd_t              fifo_mem [FIFO_DEPTH];

  // Handshake: the head is offered whenever cmd_valid is high and stays frozen
  // until a rising edge sees cmd_valid && cmd_ready; a RESTART flush cancels it.
  assign flush     = press[2];
  assign full      = (fifo_count == 3'(FIFO_DEPTH));
  assign pop       = cmd_valid & cmd_ready & ~flush;
  assign can_write = ~flush & (~full | pop);
  assign push      = can_write & (wr_cmd.op != OP_NONE);

  always_comb begin
    wr_cmd.op   = OP_NONE;
    wr_cmd.tile = '0;
    if (pend_rst) begin
      wr_cmd.op = OP_RESTART;
    end else if (pend_sel) begin
      wr_cmd.op   = OP_SELECT;
      wr_cmd.tile = sel_tile;
    end else if (pend_cfm) begin
      wr_cmd.op = OP_CONFIRM;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      pend_sel <= 1'b0;
      pend_cfm <= 1'b0;
      pend_rst <= 1'b0;
      sel_tile <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= overflow | (press[0] & pend_sel) | (press[1] & pend_cfm)
                           | (press[2] & pend_rst);
      if (push && wr_cmd.op == OP_SELECT)  pend_sel <= 1'b0;
      if (push && wr_cmd.op == OP_CONFIRM) pend_cfm <= 1'b0;
      if (push && wr_cmd.op == OP_RESTART) pend_rst <= 1'b0;
      // A press arriving while its flag is still set is dropped, even if the
      // earlier command is leaving the flag this very cycle.
      if (press[0] && !pend_sel) begin
        pend_sel <= 1'b1;
        sel_tile <= sw_s2[TILE_W-1:0];
      end
      if (press[1] && !pend_cfm) pend_cfm <= 1'b1;
      if (press[2] && !pend_rst) pend_rst <= 1'b1;
      if (flush) begin
        pend_sel <= 1'b0;
        pend_cfm <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (push) fifo_mem[wr_ptr] <= wr_cmd;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 3'(1);
        2'b01:   fifo_count <= fifo_count - 3'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign head      = fifo_mem[rd_ptr];
  assign cmd_valid = (fifo_count != 3'd0);
  assign cmd_op    = cmd_valid ? head.op   : OP_NONE;
  assign cmd_tile  = cmd_valid ? head.tile : '0;

endmodule

// File: tb/tb_tile_input_ctrl.sv
// Directed bench for tile_input_ctrl: expected commands are queued as presses are
// issued and a negedge monitor pops and compares on every accepted handshake.
module tb_tile_input_ctrl;

  localparam int D = 4;
  localparam logic [1:0] SEL = 2'b01, CFM = 2'b10, RST = 2'b11;

  logic       clk = 1'b0;
  logic       resetn;
  logic [2:0] key;
  logic [9:0] sw;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_tile;
  logic [2:0] fifo_count;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;
  logic [5:0] exp_q[$];

  tile_input_ctrl #(.DEBOUNCE_CYCLES(D), .FIFO_DEPTH(4)) dut (
    .CLOCK_50(clk), .resetn(resetn), .KEY(key), .SW(sw),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_tile(cmd_tile), .fifo_count(fifo_count), .overflow(overflow));

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold_keys(input logic [2:0] mask, input int cycles);
    key = key & ~mask;
    tick(cycles);
    key = key | mask;
    tick(12);
  endtask

  task automatic wait_count(input string name, input logic [2:0] n, input int budget);
    for (int i = 0; i < budget && fifo_count !== n; i++) tick(1);
    check(name, fifo_count, n);
  endtask

  task automatic drain(input string name);
    cmd_ready = 1'b1;
    wait_count(name, 3'd0, 40);
    tick(2);
    cmd_ready = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (resetn && cmd_valid && cmd_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_cmd", {cmd_op, cmd_tile}, 6'h3f);
      end else begin
        check("cmd_head", {cmd_op, cmd_tile}, exp_q.pop_front());
      end
    end
  end

  initial begin
    resetn = 1'b0; key = 3'b111; sw = '0; cmd_ready = 1'b0;
    tick(3);
    check("rst_valid", cmd_valid, 0);
    check("rst_op", cmd_op, 0);
    check("rst_tile", cmd_tile, 0);
    check("rst_count", fifo_count, 0);
    check("rst_overflow", overflow, 0);
    resetn = 1'b1;
    tick(3);

    // single SELECT, latency D+4
    sw = 10'h005;
    exp_q.push_back({SEL, 4'd5});
    key[0] = 1'b0;
    tick(8);
    check("lat_not_yet", cmd_valid, 0);
    tick(1);
    check("lat_valid", cmd_valid, 1);
    check("lat_op", cmd_op, SEL);
    check("lat_tile", cmd_tile, 5);
    check("lat_count", fifo_count, 1);
    tick(1);
    key[0] = 1'b1;
    drain("lat_drain");
    tick(10);

    // bouncing KEY2 -> exactly one CONFIRM
    cmd_ready = 1'b1;
    exp_q.push_back({CFM, 4'd0});
    for (int r = 0; r < 3; r++) begin
      key[1] = 1'b0; tick(3);
      key[1] = 1'b1; tick(1);
    end
    hold_keys(3'b010, 10);
    tick(6);
    check("bounce_delivered", exp_q.size(), 0);
    check("bounce_count", fifo_count, 0);
    cmd_ready = 1'b0;

    // simultaneous SELECT and CONFIRM
    sw = 10'h009;
    exp_q.push_back({SEL, 4'd9});
    exp_q.push_back({CFM, 4'd0});
    key[1:0] = 2'b00;
    tick(9);
    check("simul_count1", fifo_count, 1);
    check("simul_head1", {cmd_op, cmd_tile}, {SEL, 4'd9});
    tick(1);
    check("simul_count2", fifo_count, 2);
    check("simul_head2", {cmd_op, cmd_tile}, {SEL, 4'd9});
    key[1:0] = 2'b11;
    tick(12);
    drain("simul_drain");

    // RESTART flushes a three-entry queue
    sw = 10'h002;
    hold_keys(3'b011, 6);
    sw = 10'h003;
    hold_keys(3'b001, 6);
    check("flush_pre_count", fifo_count, 3);
    exp_q.delete();
    exp_q.push_back({RST, 4'd0});
    key[2] = 1'b0;
    tick(8);
    check("flush_count0", fifo_count, 0);
    tick(1);
    check("flush_count1", fifo_count, 1);
    check("flush_head", {cmd_op, cmd_tile}, {RST, 4'd0});
    key[2] = 1'b1;
    tick(12);
    check("flush_count_stable", fifo_count, 1);
    drain("flush_drain");

    // full queue, pending fifth, overflow on sixth
    for (int t = 1; t <= 5; t++) begin
      sw = 10'(t);
      exp_q.push_back({SEL, 4'(t)});
      hold_keys(3'b001, 6);
    end
    check("full_count", fifo_count, 4);
    check("full_no_overflow", overflow, 0);
    sw = 10'h006;
    hold_keys(3'b001, 6);
    check("overflow_set", overflow, 1);
    check("overflow_count", fifo_count, 4);
    drain("overflow_drain");
    check("overflow_sticky", overflow, 1);

    // reset mid-operation with KEY1 held through reset
    sw = 10'h007;
    hold_keys(3'b011, 6);
    wait_count("mid_pre_count", 3'd2, 10);
    key[0] = 1'b0;
    tick(3);
    resetn = 1'b0;
    #1;
    check("mid_valid", cmd_valid, 0);
    check("mid_op", cmd_op, 0);
    check("mid_tile", cmd_tile, 0);
    check("mid_count", fifo_count, 0);
    check("mid_overflow", overflow, 0);
    exp_q.delete();
    tick(2);
    exp_q.push_back({SEL, 4'd7});
    resetn = 1'b1;
    tick(8);
    check("mid_no_early_cmd", cmd_valid, 0);
    tick(1);
    check("mid_redebounced", {cmd_valid, cmd_op, cmd_tile}, {1'b1, SEL, 4'd7});
    key[0] = 1'b1;
    drain("mid_drain");
    tick(12);
    check("final_queue_empty", exp_q.size(), 0);
    check("final_count", fifo_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tile_input_ctrl.md
TILE_INPUT_CTRL -- requirements
Module: tile_input_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning consecutive stable cycles before a key change is accepted (500000 on board).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning command queue entries (power of two).
REQ-003 SHALL have port CLOCK_50  input  1  sole clock, all flops on rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port KEY  input  3  raw active-low pushbuttons KEY[3:1] (bit0=KEY1).
REQ-006 SHALL have port SW  input  10  raw slide switches; SW[3:0] is the tile index.
REQ-007 SHALL have port cmd_valid  output  1  queue head holds a command.
REQ-008 SHALL have port cmd_ready  input  1  game FSM accepts head this cycle.
REQ-009 SHALL have port cmd_op  output  2  head opcode: 01 SELECT, 10 CONFIRM, 11 RESTART.
REQ-010 SHALL have port cmd_tile  output  4  head tile index (SELECT only, else 0).
REQ-011 SHALL have port fifo_count  output  3  entries in queue, 0..FIFO_DEPTH.
REQ-012 SHALL have port overflow  output  1  sticky: a press was lost.

Function
REQ-013 SHALL pass KEY and SW through 2-flop synchronizers before any other use.
REQ-014 SHALL debounce each key independently: debounced state flips on the DEBOUNCE_CYCLES-th consecutive edge where synced input differs from it; counter clears on any cycle input equals debounced state.
REQ-015 SHALL generate a one-cycle press pulse on debounced 1->0 only; releases generate nothing.
REQ-016 SHALL map KEY1 press -> SELECT with tile = synced SW[3:0] captured on the press-pulse cycle, KEY2 -> CONFIRM, KEY3 -> RESTART.
REQ-017 SHALL hold one pending flag per key, set on press pulse, cleared when its command is written to the queue.
REQ-018 SHALL write at most one command per cycle, priority RESTART > SELECT > CONFIRM, only when queue not full or a pop occurs the same cycle.
REQ-019 SHALL, on a press pulse for a key whose pending flag is already set, drop the press and set overflow.
REQ-020 SHALL, on a RESTART press pulse, flush the queue and clear SELECT/CONFIRM pending flags in that cycle (flush overrides a simultaneous pop/push), then enqueue RESTART per REQ-018.
REQ-021 SHALL present the queue head first-word-fall-through: cmd_valid = fifo_count != 0, cmd_op/cmd_tile = head, both 0 when empty.
REQ-022 SHALL pop exactly when cmd_valid and cmd_ready are high at a rising edge; cmd_ready while empty has no effect.
REQ-023 SHALL hold head stable while cmd_valid and not cmd_ready.
REQ-024 SHALL give latency: raw key low held from edge 0, empty idle queue -> cmd_valid high after edge DEBOUNCE_CYCLES+4.
REQ-025 SHALL wrap queue pointers modulo FIFO_DEPTH; fifo_count never exceeds FIFO_DEPTH.

Reset
REQ-026 SHALL, on resetn low, asynchronously clear: KEY sync/debounced state to 1 (released), SW sync to 0, counters, pending flags, pointers, fifo_count, cmd_valid, cmd_op, cmd_tile, overflow to 0.
REQ-027 SHALL discard any in-progress debounce or queued commands when reset asserts mid-operation; a key held through reset release produces one press after full debounce.

Structure
REQ-028 SHALL take opcode constants, TILE_W=4 and default FIFO_DEPTH from shared package tile_pkg.
REQ-029 SHALL instantiate sub-module key_debounce (sync-free counter + state + press pulse) three times.

Verification
REQ-030 KEY1 low 10 cycles, SW=0x005, DEBOUNCE_CYCLES=4 -> cmd_valid rises after edge 8, op=01 tile=5; cmd_ready=1 -> count 0.
REQ-031 KEY2 bouncing low 3 cycles/high 1 cycle x3 then held low -> exactly one CONFIRM queued.
REQ-032 cmd_ready=0, five SELECT presses -> fifo_count=4, fifth waits pending; sixth press before drain -> overflow=1.
REQ-033 KEY1 and KEY2 pulses same cycle -> SELECT queued first, CONFIRM next cycle.
REQ-034 Queue holds 3 entries, KEY3 press -> queue flushed, then single RESTART op=11, fifo_count=1.
REQ-035 resetn low while fifo_count=2 and KEY1 debouncing -> all outputs 0 immediately; no command until full re-debounce.
